// File: rtl/mem_block_copy.sv
// mem_block_copy: DMA-style word copy engine, sole driver of the data memory port while busy.
// Latency: 1 + length*(2+READ_LATENCY) cycles from the accepted start edge to the done pulse.
// Backpressure: none; start is sampled only in IDLE, and start while busy is dropped (never queued).
// Optional abort input/aborted output is enabled by defining MEM_BLOCK_COPY_ABORT_EN.
module mem_block_copy #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int READ_LATENCY = 1   // legal range 1..4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        src_addr,
  input  logic [ADDR_W-1:0]        dst_addr,
  input  logic [ADDR_W-1:0]        length,
`ifdef MEM_BLOCK_COPY_ABORT_EN
  input  logic                     abort,
  output logic                     aborted,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [ADDR_W-1:0]        words_copied,
  output logic                     mem_write_enable,
  output logic                     mem_read_enable,
  output logic [ADDR_W-1:0]        mem_address,
  output logic signed [DATA_W-1:0] mem_write_data,
  input  logic signed [DATA_W-1:0] mem_read_data
);

  // Wide enough to count up to the largest legal read latency.
  localparam int                WAIT_W    = 3;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD    = 3'd1,
    S_RWAIT = 3'd2,
    S_WR    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                   state;
  state_t                   nxt_state;
  logic [ADDR_W-1:0]        src_ptr;
  logic [ADDR_W-1:0]        dst_ptr;
  logic [ADDR_W-1:0]        remaining;
  logic [WAIT_W-1:0]        wait_cnt;
  logic signed [DATA_W-1:0] data_reg;

  logic [ADDR_W-1:0]        nxt_src;
  logic [ADDR_W-1:0]        nxt_dst;
  logic [ADDR_W-1:0]        nxt_rem;
  logic [ADDR_W-1:0]        nxt_wc;
  logic [WAIT_W-1:0]        nxt_wait;
  logic signed [DATA_W-1:0] nxt_data;
  logic                     nxt_rd_en;
  logic                     nxt_wr_en;
  logic                     nxt_busy;
  logic                     nxt_done;
  logic [ADDR_W-1:0]        nxt_addr;
  logic signed [DATA_W-1:0] nxt_wdata;
  logic                     start_ok;
`ifdef MEM_BLOCK_COPY_ABORT_EN
  logic                     abort_hit;
`endif

  // Next-state, pointer and counter update for the read-then-write sequence.
  always_comb begin
    nxt_state = state;
    nxt_src   = src_ptr;
    nxt_dst   = dst_ptr;
    nxt_rem   = remaining;
    nxt_wc    = words_copied;
    nxt_wait  = wait_cnt;
    nxt_data  = data_reg;
    start_ok  = 1'b0;
`ifdef MEM_BLOCK_COPY_ABORT_EN
    abort_hit = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok  = 1'b1;
          nxt_src   = src_addr;
          nxt_dst   = dst_addr;
          nxt_rem   = length;
          nxt_wc    = '0;
          nxt_state = (length == '0) ? S_DONE : S_RD;
        end
      end
      S_RD: begin
        nxt_wait  = '0;
        nxt_state = S_RWAIT;
      end
      S_RWAIT: begin
        // Read data is only guaranteed on the final wait cycle.
        if (wait_cnt == WAIT_LAST) begin
          nxt_data  = mem_read_data;
          nxt_state = S_WR;
        end else begin
          nxt_wait = wait_cnt + WAIT_W'(1);
        end
      end
      S_WR: begin
        // Pointers wrap naturally at 2^ADDR_W.
        nxt_src   = src_ptr + ADDR_W'(1);
        nxt_dst   = dst_ptr + ADDR_W'(1);
        nxt_rem   = remaining - ADDR_W'(1);
        nxt_wc    = words_copied + ADDR_W'(1);
        nxt_state = (remaining == ADDR_W'(1)) ? S_DONE : S_RD;
      end
      S_DONE: begin
        nxt_state = S_IDLE;
      end
      default: begin
        nxt_state = S_IDLE;
      end
    endcase

`ifdef MEM_BLOCK_COPY_ABORT_EN
    // The access of the current cycle still lands (and a write still counts);
    // only the sequencing that follows is cut short.
    if (abort && (state == S_RD || state == S_RWAIT || state == S_WR)) begin
      abort_hit = 1'b1;
      nxt_state = S_DONE;
    end
`endif
  end

  // Output values decoded from the next state so every port is driven straight from a flop.
  always_comb begin
    nxt_rd_en = (nxt_state == S_RD);
    nxt_wr_en = (nxt_state == S_WR);
    nxt_busy  = (nxt_state == S_RD) || (nxt_state == S_RWAIT) || (nxt_state == S_WR);
    nxt_done  = (nxt_state == S_DONE);
    nxt_addr  = mem_address;
    nxt_wdata = mem_write_data;
    if (nxt_rd_en) begin
      nxt_addr = nxt_src;
    end else if (nxt_wr_en) begin
      nxt_addr  = nxt_dst;
      nxt_wdata = nxt_data;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= S_IDLE;
      src_ptr          <= '0;
      dst_ptr          <= '0;
      remaining        <= '0;
      wait_cnt         <= '0;
      data_reg         <= '0;
      words_copied     <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
    end else begin
      state            <= nxt_state;
      src_ptr          <= nxt_src;
      dst_ptr          <= nxt_dst;
      remaining        <= nxt_rem;
      wait_cnt         <= nxt_wait;
      data_reg         <= nxt_data;
      words_copied     <= nxt_wc;
      busy             <= nxt_busy;
      done             <= nxt_done;
      mem_read_enable  <= nxt_rd_en;
      mem_write_enable <= nxt_wr_en;
      mem_address      <= nxt_addr;
      mem_write_data   <= nxt_wdata;
    end
  end

`ifdef MEM_BLOCK_COPY_ABORT_EN
  // Sticky abort flag: raised alongside the early done, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      aborted <= 1'b0;
    end else if (start_ok) begin
      aborted <= 1'b0;
    end else if (abort_hit) begin
      aborted <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_block_copy.sv
// tb_mem_block_copy: randomized copies against a sequential word-copy reference model.
// Stimulus pushes expected reads, writes and done records; a negedge monitor pops and compares.
// Memory is modelled behaviourally with a READ_LATENCY-deep read pipeline.
module tb_mem_block_copy;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int RL     = 1;
  localparam int WCOST  = 2 + RL;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] src_addr;
  logic [ADDR_W-1:0] dst_addr;
  logic [ADDR_W-1:0] length;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] words_copied;
  logic              mem_write_enable;
  logic              mem_read_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;
`ifdef MEM_BLOCK_COPY_ABORT_EN
  logic              abort;
  logic              aborted;
`endif

  mem_block_copy #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(RL)) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .src_addr         (src_addr),
    .dst_addr         (dst_addr),
    .length           (length),
`ifdef MEM_BLOCK_COPY_ABORT_EN
    .abort            (abort),
    .aborted          (aborted),
`endif
    .busy             (busy),
    .done             (done),
    .words_copied     (words_copied),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [15:0] init_val(input int a);
    return 16'((a * 40503) ^ 32'h5A5A);
  endfunction

  // Behavioural memory: single writer process, backdoor init/poke, pipelined read data.
  logic [15:0] mem   [65536];
  logic [15:0] model [65536];
  logic [15:0] rd_pipe [RL];
  logic        mem_init;
  logic        poke_vld;
  logic [15:0] poke_addr;
  logic [15:0] poke_dat;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_init) begin
      for (int a = 0; a < 65536; a++) mem[a] <= init_val(a);
    end else if (poke_vld) begin
      mem[poke_addr] <= poke_dat;
    end else if (mem_write_enable) begin
      mem[mem_address] <= mem_write_data;
    end
    rd_pipe[0] <= mem_read_enable ? mem[mem_address] : 16'hDEAD;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_read_data = rd_pipe[RL-1];

  typedef struct { logic [15:0] addr; logic [15:0] data; } wr_t;
  typedef struct { int done_edge; logic [15:0] wc; bit ab; } dn_t;
  logic [15:0] exp_rd[$];
  wr_t         exp_wr[$];
  dn_t         exp_dn[$];

  // Monitor: every memory access and done pulse must match the next expected entry.
  always @(negedge clk) begin
    logic [15:0] ea;
    wr_t w;
    dn_t r;
    if (mem_read_enable || mem_write_enable)
      check("enable_mutex", {31'd0, mem_read_enable & mem_write_enable}, 32'd0);
    if (mem_read_enable) begin
      check("read_expected", {31'd0, exp_rd.size() > 0}, 32'd1);
      if (exp_rd.size() > 0) begin
        ea = exp_rd.pop_front();
        check("read_addr", {16'd0, mem_address}, {16'd0, ea});
      end
    end
    if (mem_write_enable) begin
      check("write_expected", {31'd0, exp_wr.size() > 0}, 32'd1);
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        check("write_addr", {16'd0, mem_address}, {16'd0, w.addr});
        check("write_data", {16'd0, mem_write_data}, {16'd0, w.data});
      end
    end
    if (done) begin
      check("done_expected", {31'd0, exp_dn.size() > 0}, 32'd1);
      if (exp_dn.size() > 0) begin
        r = exp_dn.pop_front();
        check("done_edge", cyc + 1, r.done_edge);
        check("done_words_copied", {16'd0, words_copied}, {16'd0, r.wc});
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
`ifdef MEM_BLOCK_COPY_ABORT_EN
        check("aborted_flag", {31'd0, aborted}, {31'd0, r.ab});
`endif
      end
    end
  end

  task automatic poke(input logic [15:0] a, input logic [15:0] v);
    @(negedge clk);
    poke_vld = 1'b1; poke_addr = a; poke_dat = v;
    model[a] = v;
    @(negedge clk);
    poke_vld = 1'b0;
  endtask

  // Reference: n_wr words copied in strict ascending order, one at a time.
  task automatic issue(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                       input int n_rd, input int n_wr, input bit exp_done, input bit exp_ab,
                       input int done_delta);
    logic [15:0] ra, wa;
    wr_t w;
    dn_t r;
    for (int i = 0; i < n_rd; i++) begin
      ra = s + 16'(i);
      exp_rd.push_back(ra);
    end
    for (int i = 0; i < n_wr; i++) begin
      ra = s + 16'(i);
      wa = d + 16'(i);
      model[wa] = model[ra];
      w.addr = wa; w.data = model[wa];
      exp_wr.push_back(w);
    end
    @(negedge clk);
    src_addr = s; dst_addr = d; length = l; start = 1'b1;
    r.done_edge = cyc + 1 + done_delta; r.wc = 16'(n_wr); r.ab = exp_ab;
    if (exp_done) exp_dn.push_back(r);
    @(negedge clk);
    start = 1'b0;
    src_addr = 16'($urandom); dst_addr = 16'($urandom); length = 16'($urandom);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin seen = 1'b1; break; end
      @(negedge clk);
    end
    check("done_seen", {31'd0, seen}, 32'd1);
  endtask

  task automatic post_check();
    int diffs = 0;
    @(negedge clk);
    check("rd_queue_drained", exp_rd.size(), 0);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("done_queue_drained", exp_dn.size(), 0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    for (int a = 0; a < 65536; a++) if (mem[a] !== model[a]) diffs++;
    check("mem_image", diffs, 0);
    exp_rd.delete(); exp_wr.delete(); exp_dn.delete();
  endtask

  task automatic copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l);
    issue(s, d, l, int'(l), int'(l), 1'b1, 1'b0, 1 + int'(l) * WCOST);
    wait_done();
    post_check();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] s, d, l;
    bit hit;
    rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    mem_init = 1'b1; poke_vld = 1'b0; poke_addr = '0; poke_dat = '0;
`ifdef MEM_BLOCK_COPY_ABORT_EN
    abort = 1'b0;
`endif
    for (int a = 0; a < 65536; a++) model[a] = init_val(a);
    @(negedge clk);
    mem_init = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_words_copied", {16'd0, words_copied}, 32'd0);
    check("rst_wr_en", {31'd0, mem_write_enable}, 32'd0);
    check("rst_rd_en", {31'd0, mem_read_enable}, 32'd0);
    check("rst_address", {16'd0, mem_address}, 32'd0);
    check("rst_write_data", {16'd0, mem_write_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic three-word copy of signed data.
    poke(16'd10, 16'(-1234)); poke(16'd11, 16'd5678); poke(16'd12, 16'd9999);
    copy(16'd10, 16'd200, 16'd3);
    check("basic_w0", {16'd0, mem[200]}, {16'd0, 16'hFB2E});
    check("basic_w1", {16'd0, mem[201]}, 32'd5678);
    check("basic_w2", {16'd0, mem[202]}, 32'd9999);
    check("basic_words_copied_hold", {16'd0, words_copied}, 32'd3);

    // Zero length: immediate done, no accesses; a start during DONE is dropped.
    issue(16'd5, 16'd6, 16'd0, 0, 0, 1'b1, 1'b0, 1);
    src_addr = 16'd7; dst_addr = 16'd8; length = 16'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    post_check();
    check("zero_len_words_copied", {16'd0, words_copied}, 32'd0);

    // Address wrap at the top of memory.
    poke(16'hFFFF, 16'd7); poke(16'h0000, 16'd8);
    copy(16'hFFFF, 16'd100, 16'd2);
    check("wrap_w0", {16'd0, mem[100]}, 32'd7);
    check("wrap_w1", {16'd0, mem[101]}, 32'd8);

    // Overlap replicates the first word; a start mid-transfer is ignored.
    poke(16'd50, 16'd42);
    issue(16'd50, 16'd51, 16'd3, 3, 3, 1'b1, 1'b0, 1 + 3 * WCOST);
    repeat (3) @(negedge clk);
    src_addr = 16'd0; dst_addr = 16'd300; length = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    post_check();
    for (int i = 51; i <= 53; i++) check("overlap_fill", {16'd0, mem[i]}, 32'd42);

    // Randomized copies, biased towards overlapping and wrapping regions.
    for (int t = 0; t < 12; t++) begin
      s = 16'($urandom);
      case ($urandom_range(0, 2))
        0: d = s + 16'($urandom_range(0, 3));
        1: d = s - 16'($urandom_range(0, 3));
        default: d = 16'($urandom);
      endcase
      if (t == 5) s = 16'hFFFD;
      l = 16'($urandom_range(1, 6));
      copy(s, d, l);
    end

    // Reset during the second write of a four-word copy.
    issue(16'd400, 16'd500, 16'd4, 2, 2, 1'b0, 1'b0, 0);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_write_enable && mem_address == 16'd501) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    check("reset_target_write_seen", {31'd0, hit}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_wr_en", {31'd0, mem_write_enable}, 32'd0);
    check("midrst_rd_en", {31'd0, mem_read_enable}, 32'd0);
    check("midrst_words_copied", {16'd0, words_copied}, 32'd0);
    rst = 1'b0;
    repeat (3 * WCOST) @(negedge clk);
    post_check();

`ifdef MEM_BLOCK_COPY_ABORT_EN
    // Abort during the read wait of word 2 of a five-word copy.
    issue(16'd600, 16'd700, 16'd5, 2, 1, 1'b1, 1'b1, WCOST + 3);
    repeat (WCOST + 1) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done();
    post_check();
    check("abort_words_copied", {16'd0, words_copied}, 32'd1);
    copy(16'd20, 16'd40, 16'd2);
    check("aborted_cleared", {31'd0, aborted}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
